// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register round-robin arbiter.
// Contents:
//   DefNreq / DefWidth / DefMaxBurst - default parameter values
//   arb_state_e                      - IDLE/OWNED view of the grant register
//   clog2()                          - index width helper, never returns less than 1
package shared_reg_arbiter_pkg;

    localparam int unsigned DefNreq     = 4;
    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefMaxBurst = 2;

    typedef enum logic [0:0] {
        StIdle,
        StOwned
    } arb_state_e;

    // Minimum of 1 so that single-value counters and indices still get a real bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bus between the producer blocks and the shared-register arbiter.
// Signals:
//   req     - per-requester write request (level)
//   wdata   - packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt     - registered one-hot grant of the last write
//   q       - shared register contents
//   q_valid - a write happened at the last edge
//   q_owner - index of the last writer
// Modports: master (producers), slave (arbiter).
interface shared_reg_arbiter_if
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = DefNreq,
    parameter int unsigned WIDTH = DefWidth
);

    localparam int unsigned OW = clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [OW-1:0]         q_owner;

    modport master (
        output req,
        output wdata,
        input  gnt,
        input  q,
        input  q_valid,
        input  q_owner
    );

    modport slave (
        input  req,
        input  wdata,
        output gnt,
        output q,
        output q_valid,
        output q_owner
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Ports:
//   req     (in)  - request vector
//   ptr     (in)  - last winner; scanning starts at ptr+1 and ends at ptr itself
//   win     (out) - first requesting index found, 0 when nothing requests
//   any_req (out) - at least one request is active
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   win,
    output logic            any_req
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        // Modulo wrap keeps candidates below NREQ for non-power-of-two counts.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = PW'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among NREQ requesters.
// The current owner may keep the register for up to MAX_BURST consecutive
// grants while it keeps requesting; then priority rotates past it.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - shared_reg_arbiter_if slave: req/wdata in, gnt/q/q_valid/q_owner out
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = DefNreq,
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned MAX_BURST = DefMaxBurst
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_reg_arbiter_if.slave   bus
);

    localparam int unsigned   PW        = clog2(NREQ);
    localparam int unsigned   BW        = clog2(MAX_BURST);
    localparam logic [BW-1:0] BurstLast = BW'(MAX_BURST - 1);
    localparam logic [PW-1:0] PtrInit   = PW'(NREQ - 1);

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic [PW-1:0]    q_owner_q, q_owner_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [BW-1:0]    burst_q, burst_d;

    logic [PW-1:0]    pick_win;
    logic [PW-1:0]    win;
    logic             any_req;
    arb_state_e       state;

    assign state = (gnt_q != '0) ? StOwned : StIdle;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win     (pick_win),
        .any_req (any_req)
    );

    always_comb begin
        gnt_d     = gnt_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        q_owner_d = q_owner_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        win       = pick_win;
        if (!any_req) begin
            gnt_d     = '0;
            q_valid_d = 1'b0;
            burst_d   = '0;
        end else begin
            // While OWNED, ptr_q is the current owner.
            if (state == StOwned && bus.req[ptr_q] && burst_q < BurstLast) begin
                win     = ptr_q;
                burst_d = burst_q + BW'(1);
            end else begin
                win     = pick_win;
                burst_d = '0;
            end
            gnt_d     = NREQ'(1) << win;
            q_d       = bus.wdata[32'(win)*WIDTH +: WIDTH];
            q_owner_d = win;
            ptr_d     = win;
            q_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_owner_q <= '0;
            ptr_q     <= PtrInit;
            burst_q   <= '0;
        end else begin
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_owner_q <= q_owner_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.q_owner = q_owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: hand-built vector table, an asynchronous
// mid-burst reset sequence, and random traffic against a run-length model.
module tb_shared_reg_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 2;
    localparam logic [31:0] ALL = 32'h44332211;

    logic clk = 1'b0;
    logic rst;

    shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    shared_reg_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic [7:0] qq,
                             input logic qv, input logic [1:0] own);
        check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({tag, ".q"}, 32'(bus.q), 32'(qq));
        check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(qv));
        check({tag, ".q_owner"}, 32'(bus.q_owner), 32'(own));
    endtask

    // Reference model: tracks the last writer and how many consecutive grants
    // it has received in its current run.
    logic [3:0] m_gnt;
    logic [7:0] m_q;
    logic       m_qv;
    int         m_owner;
    int         m_ptr;
    int         m_run;

    task automatic model_reset();
        m_gnt = '0; m_q = '0; m_qv = 1'b0; m_owner = 0; m_ptr = NREQ - 1; m_run = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [31:0] wd);
        int w;
        bit found;
        if (r == 4'b0000) begin
            m_gnt = '0; m_qv = 1'b0; m_run = 0;
        end else begin
            w = 0;
            if (m_gnt != 0 && r[m_ptr] && m_run < MAX_BURST) begin
                w = m_ptr;
                m_run++;
            end else begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && r[(m_ptr + k) % NREQ]) begin
                        w = (m_ptr + k) % NREQ;
                        found = 1;
                    end
                end
                m_run = 1;
            end
            m_gnt = 4'b0001 << w;
            m_q = wd[w*WIDTH +: WIDTH];
            m_owner = w;
            m_ptr = w;
            m_qv = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bus.req, bus.wdata);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.wdata = '0;
        model_reset();
        #1;
        check_out("reset", 4'b0000, 8'h00, 1'b0, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rst_first;
        logic [3:0] req;
        logic [31:0] wdata;
        logic [3:0] gnt;
        logic [7:0] q;
        logic       qv;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rf, input logic [3:0] r, input logic [31:0] wd,
                       input logic [3:0] g, input logic [7:0] qq, input logic qv,
                       input logic [1:0] own);
        vec_t v;
        v.rst_first = rf; v.req = r; v.wdata = wd; v.gnt = g; v.q = qq; v.qv = qv; v.owner = own;
        vecs.push_back(v);
    endtask

    initial begin
        bus.req = '0;
        bus.wdata = '0;
        rst = 1'b0;

        // Idle after reset, then a lone requester regranted across burst expiry.
        add(1, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 2'd0);
        add(0, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 2'd0);
        add(0, 4'b0000, 32'h0, 4'b0000, 8'h00, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) add(0, 4'b0010, 32'h00005A00, 4'b0010, 8'h5A, 1'b1, 2'd1);
        // All requesters: two grants each in rotation.
        add(1, 4'b1111, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);
        add(0, 4'b1111, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);
        add(0, 4'b1111, ALL, 4'b0010, 8'h22, 1'b1, 2'd1);
        add(0, 4'b1111, ALL, 4'b0010, 8'h22, 1'b1, 2'd1);
        add(0, 4'b1111, ALL, 4'b0100, 8'h33, 1'b1, 2'd2);
        add(0, 4'b1111, ALL, 4'b0100, 8'h33, 1'b1, 2'd2);
        add(0, 4'b1111, ALL, 4'b1000, 8'h44, 1'b1, 2'd3);
        add(0, 4'b1111, ALL, 4'b1000, 8'h44, 1'b1, 2'd3);
        add(0, 4'b1111, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);
        add(0, 4'b1111, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);
        // Owner 1 drops on its second grant; then idle and restart from ptr+1.
        add(1, 4'b1111, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);
        add(0, 4'b1111, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);
        add(0, 4'b1111, ALL, 4'b0010, 8'h22, 1'b1, 2'd1);
        add(0, 4'b1101, ALL, 4'b0100, 8'h33, 1'b1, 2'd2);
        add(0, 4'b1111, ALL, 4'b0100, 8'h33, 1'b1, 2'd2);
        add(0, 4'b0000, ALL, 4'b0000, 8'h33, 1'b0, 2'd2);
        add(0, 4'b1001, ALL, 4'b1000, 8'h44, 1'b1, 2'd3);
        add(0, 4'b1001, ALL, 4'b1000, 8'h44, 1'b1, 2'd3);
        add(0, 4'b1001, ALL, 4'b0001, 8'h11, 1'b1, 2'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            bus.req = vecs[i].req;
            bus.wdata = vecs[i].wdata;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].q, vecs[i].qv,
                      vecs[i].owner);
        end

        // Reset asserted between edges in the middle of a burst.
        do_reset();
        bus.req = 4'b1111;
        bus.wdata = ALL;
        step();
        check_out("preburst", 4'b0001, 8'h11, 1'b1, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b0000, 8'h00, 1'b0, 2'd0);
        bus.req = 4'b1001;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        check_out("post_rst", 4'b0001, 8'h11, 1'b1, 2'd0);

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.wdata = $urandom;
            step();
            check_out($sformatf("rand%0d", c), m_gnt, m_q, m_qv, 2'(m_owner));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter that shares one WIDTH-bit D-register between NREQ requesters.
- Each cycle, one requesting client is granted and its data is clocked into the shared register.
- A bounded burst lets the current owner keep the register for up to MAX_BURST consecutive cycles before priority rotates.
- Sits between several producer blocks and a single storage/flip-flop stage in the sequential datapath.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, data width of the shared register
- MAX_BURST, 2, max consecutive grants to one owner while others are requesting (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester write request, level-sensitive, sampled at posedge clk
- wdata  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant; bit i high means requester i's data was written at the last edge
- q  output  WIDTH  shared register contents
- q_valid  output  1  high for one cycle after each edge that performed a write
- q_owner  output  clog2(NREQ)  index of the last writer

Behaviour:
- One clock domain. Single asynchronous active-high reset, named rst. No other reset.
- Reset (immediate on rst high, no clock needed):
  - gnt=0, q=0, q_valid=0, q_owner=0, burst_cnt=0
  - last-winner pointer ptr=NREQ-1, so requester 0 has top priority first
- State encoding: IDLE (gnt==0) and OWNED (gnt!=0), derived from the gnt register.
- At each posedge with rst low:
  - If req==0:
    - gnt<=0, q_valid<=0, burst_cnt<=0
    - q, q_owner and ptr hold
    - next state IDLE
  - Else if OWNED, req[ptr]=1 and burst_cnt<MAX_BURST-1:
    - win=ptr, burst_cnt<=burst_cnt+1
  - Otherwise:
    - win = first set req bit scanning ptr+1, ptr+2, ... wrapping modulo NREQ, ending at ptr itself
    - burst_cnt<=0
    - Work-conserving: if ptr is the only requester after its burst expires, it is regranted with a fresh burst.
  - On every write: gnt<=onehot(win), q<=wdata[win], q_owner<=win, ptr<=win, q_valid<=1.
- Latency: req/wdata sampled at edge k; q, gnt, q_valid and q_owner reflect that write in cycle k..k+1. Exactly one register stage, with no combinational path from req to gnt.
- A requester that drops req while owning loses ownership at the next edge, with no penalty. Re-raising req competes normally from ptr+1.
- A simultaneous drop of the owner and raise of another requester: the new requester is granted at that edge.
- gnt is always one-hot or zero, and q changes only on edges where gnt becomes nonzero.
- Reset mid-burst: all state clears asynchronously. After release, arbitration restarts from requester 0.
- NREQ not a power of two: the wrap uses modulo NREQ, and indices >= NREQ are never granted.

Decomposition:
- Shared package shared_reg_arbiter_pkg:
  - clog2 helper function
  - default parameter constants
- Sub-module rr_pick:
  - Purely combinational rotate-priority encoder
  - Inputs: req and ptr. Outputs: win index and any_req.
  - Instantiated once.
- The top holds all registers: gnt, q, q_owner, ptr, burst_cnt.

Test Plan:
All scenarios use NREQ=4, WIDTH=8, MAX_BURST=2.
- After reset release, req=0000 for 3 cycles -> gnt=0000, q=8'h00, q_valid=0, q_owner=0.
- req=0010 with wdata[1]=8'h5A held 4 cycles -> gnt=0010 every cycle, q=8'h5A, q_valid=1, q_owner=1 (burst expiry with a single requester regrants).
- req=1111 with wdata[i]=8'h11*(i+1), held from reset -> grant order 0,0,1,1,2,2,3,3,0,0, and q follows 11,11,22,22,33,33,44,44,11,11.
- During the all-request run, drop req[1] on the cycle it would get its second grant -> requester 2 granted at that edge, with burst_cnt restarted.
- Drop req to 0000 after q=8'h33 -> gnt=0000, q_valid=0, q stays 8'h33, q_owner stays 2. Then raise req=1001 -> requester 3 wins, since scanning starts from ptr+1=3.
- Assert rst between clock edges mid-burst -> gnt, q, q_valid and q_owner go to 0 before the next edge. After release, req=1001 -> requester 0 wins first.
